// File: rtl/mem_req_arbiter.sv
// N-channel memory address-bus arbiter: work-conserving round-robin by default,
// strict fixed-slot TDM when ARB_FIXED_SLOT_EN is defined.
module mem_req_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 15,
  parameter int SLOT_CYCLES = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NUM_CH-1:0]                         req_i,
  input  logic [NUM_CH*ADDR_W-1:0]                  addr_in_i,
  output logic [NUM_CH-1:0]                         gnt_o,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] gnt_id_o,
  output logic [ADDR_W-1:0]                         addr_out_o,
  output logic                                      addr_valid_o
);

  localparam int ID_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SLOT_CYCLES - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                    state_q, state_d;
  logic [ID_W-1:0]           ptr_q, ptr_d;
  logic [CNT_W-1:0]          slot_cnt_q, slot_cnt_d;
  logic [NUM_CH-1:0]         gnt_q, gnt_d;
  logic [ID_W-1:0]           gnt_id_q, gnt_id_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      valid_q, valid_d;

  logic                      loadEn;
  logic                      clearEn;
  logic [ID_W-1:0]           loadId;
  logic [NUM_CH*ADDR_W-1:0]  selVec;

  function automatic logic [ID_W-1:0] nextId(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

`ifdef ARB_FIXED_SLOT_EN
  logic [NUM_CH-1:0] ownerVec;

  // IDLE only marks the very first slot after reset; afterwards the slot
  // owner simply rotates every SLOT_CYCLES cycles whether or not it requests.
  always_comb begin
    state_d    = GRANT;
    ptr_d      = ptr_q;
    slot_cnt_d = slot_cnt_q - 1'b1;
    loadEn     = 1'b0;
    clearEn    = 1'b0;
    loadId     = (state_q == IDLE) ? ptr_q : nextId(ptr_q);
    ownerVec   = req_i >> loadId;
    if (state_q == IDLE || slot_cnt_q == '0) begin
      ptr_d      = loadId;
      slot_cnt_d = CNT_LOAD;
      if (ownerVec[0]) begin
        loadEn = 1'b1;
      end else begin
        clearEn = 1'b1;
      end
    end
  end
`else
  logic              slotEnd;
  logic [ID_W-1:0]   searchStart;
  logic [NUM_CH-1:0] holdVec;
  logic [NUM_CH-1:0] shReq;
  logic              pickFound;
  logic [ID_W-1:0]   pickId;
  int                idx;

  // A slot ends on count expiry or when the owner drops its request; the
  // replacement search then starts just past the owner so nobody starves.
  always_comb begin
    holdVec     = req_i >> gnt_id_q;
    slotEnd     = (state_q == GRANT) && ((slot_cnt_q == '0) || !holdVec[0]);
    searchStart = slotEnd ? nextId(gnt_id_q) : ptr_q;
  end

  always_comb begin
    pickFound = 1'b0;
    pickId    = '0;
    idx       = 0;
    shReq     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(searchStart) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      shReq = req_i >> idx;
      if (!pickFound && shReq[0]) begin
        pickFound = 1'b1;
        pickId    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    slot_cnt_d = slot_cnt_q;
    loadEn     = 1'b0;
    clearEn    = 1'b0;
    loadId     = pickId;
    if (state_q == IDLE) begin
      if (pickFound) begin
        loadEn     = 1'b1;
        state_d    = GRANT;
        slot_cnt_d = CNT_LOAD;
      end
    end else if (slotEnd) begin
      ptr_d = searchStart;
      if (pickFound) begin
        loadEn     = 1'b1;
        slot_cnt_d = CNT_LOAD;
      end else begin
        clearEn    = 1'b1;
        state_d    = IDLE;
        slot_cnt_d = '0;
      end
    end else begin
      slot_cnt_d = slot_cnt_q - 1'b1;
    end
  end
`endif

  // The address is captured once at grant time and held for the whole slot.
  always_comb begin
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    selVec   = addr_in_i >> (int'(loadId) * ADDR_W);
    if (loadEn) begin
      gnt_d    = NUM_CH'(1) << loadId;
      gnt_id_d = loadId;
      addr_d   = selVec[ADDR_W-1:0];
      valid_d  = 1'b1;
    end else if (clearEn) begin
      gnt_d    = '0;
      gnt_id_d = '0;
      addr_d   = '0;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      slot_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      slot_cnt_q <= slot_cnt_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign gnt_id_o     = gnt_id_q;
  assign addr_out_o   = addr_q;
  assign addr_valid_o = valid_q;

endmodule
